// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants for the seven-segment scan controller.
//   SEG_BLANK  : all segments off (active-low).
//   CODE_MINUS : digit code that renders a minus sign.
//   SEG_BIT_*  : bit positions inside the 8-bit segment bus (a..g, dp).
//   SEG_TABLE  : 16-entry code-to-glyph table, active-low, dp bit off.
//   seg_lookup : reads one glyph out of SEG_TABLE.
// -----------------------------------------------------------------------------
package seg_pkg;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [3:0] CODE_MINUS = 4'd10;

  localparam int SEG_BIT_A  = 7;
  localparam int SEG_BIT_B  = 6;
  localparam int SEG_BIT_C  = 5;
  localparam int SEG_BIT_D  = 4;
  localparam int SEG_BIT_E  = 3;
  localparam int SEG_BIT_F  = 2;
  localparam int SEG_BIT_G  = 1;
  localparam int SEG_BIT_DP = 0;

  // Entry n sits at bits [8n+7:8n]. Codes 11..15 are blank glyphs; the
  // minus sign occupies the CODE_MINUS slot (10).
  localparam logic [127:0] SEG_TABLE = {
    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,  // 15..11
    8'hFD,                              // 10 minus
    8'h09, 8'h01, 8'h1F, 8'h41,         // 9..6
    8'h49, 8'h99, 8'h0D, 8'h25,         // 5..2
    8'h9F, 8'h03                        // 1..0
  };

  function automatic logic [7:0] seg_lookup(input logic [3:0] code);
    logic [6:0] base_v;
    base_v = {code, 3'b000};
    return SEG_TABLE[base_v +: 8];
  endfunction

endpackage

// File: rtl/seg_decode.sv
// -----------------------------------------------------------------------------
// seg_decode
// Combinational digit decoder: 4-bit code plus decimal point to an active-low
// segment pattern.
//   code : digit code 0..15 (10 = minus, 11..15 = blank glyph)
//   dp   : 1 lights the decimal point
//   seg  : active-low segments, bit7..bit1 = a..g, bit0 = dp
// -----------------------------------------------------------------------------
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] raw_s;

  assign raw_s = seg_lookup(code);

  // Overlay the decimal point onto the looked-up glyph.
  always_comb begin
    seg = raw_s;
    if (dp) begin
      seg[SEG_BIT_DP] = 1'b0;
    end else begin
      seg[SEG_BIT_DP] = raw_s[SEG_BIT_DP];
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for common-anode seven-segment digits on a
// shared segment bus. A full image is loaded through a valid/ready port into a
// pending buffer and copied to the active image only at a frame boundary, so
// a frame is never torn. Each digit slot is PRESCALE clocks long and starts
// with one dead cycle (all anodes off) to suppress ghosting.
//
// Parameters: NUM_DIGITS (1..8, index 0 = rightmost), PRESCALE (>= 2).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_valid   : image offered
//   load_ready   : pending buffer empty
//   load_digits  : nibble i = code of position i
//   load_dp      : decimal point per position
//   load_en      : position enable (0 = dark)
//   seg          : registered active-low segments (a..g, dp)
//   an           : registered active-low anodes
//   frame_done   : one-cycle pulse in the cycle after the frame wrap
//
// Optional feature macro: LEADING_ZERO_BLANK_EN -- when defined, leading
// zero digits (without dp) are blanked; the mask is captured whenever the
// pending image becomes active.
// -----------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [4*NUM_DIGITS-1:0]   load_digits,
  input  logic [NUM_DIGITS-1:0]     load_dp,
  input  logic [NUM_DIGITS-1:0]     load_en,
  output logic [7:0]                seg,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]          presc_r;
  logic [IDX_W-1:0]          idx_r;
  logic [4*NUM_DIGITS-1:0]   act_digits_r;
  logic [NUM_DIGITS-1:0]     act_dp_r;
  logic [NUM_DIGITS-1:0]     act_en_r;
  logic [4*NUM_DIGITS-1:0]   pend_digits_r;
  logic [NUM_DIGITS-1:0]     pend_dp_r;
  logic [NUM_DIGITS-1:0]     pend_en_r;
  logic                      pend_full_r;
  logic [7:0]                seg_r;
  logic [NUM_DIGITS-1:0]     an_r;
  logic                      frame_done_r;

  logic                      tick_s;
  logic                      wrap_s;
  logic                      accept_s;
  logic                      swap_s;
  logic [NUM_DIGITS-1:0]     blank_mask_s;
  logic [3:0]                code_s;
  logic                      dp_s;
  logic                      lit_s;
  logic [7:0]                dec_seg_s;
  logic [7:0]                seg_next_s;
  logic [NUM_DIGITS-1:0]     an_next_s;

  assign tick_s     = (presc_r == PRE_LAST);
  assign wrap_s     = tick_s && (idx_r == IDX_LAST);
  assign load_ready = ~pend_full_r;
  assign accept_s   = load_valid && ~pend_full_r;
  // A swap needs a full buffer, an accept needs an empty one: never both.
  assign swap_s     = wrap_s && pend_full_r;

  // Slot prescaler and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= '0;
      idx_r   <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
      idx_r   <= (idx_r == IDX_LAST) ? '0 : idx_r + 1'b1;
    end else begin
      presc_r <= presc_r + 1'b1;
      idx_r   <= idx_r;
    end
  end

  // Pending image buffer: filled by the load port, drained at the boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_digits_r <= '0;
      pend_dp_r     <= '0;
      pend_en_r     <= '0;
      pend_full_r   <= 1'b0;
    end else if (swap_s) begin
      pend_full_r   <= 1'b0;
    end else if (accept_s) begin
      pend_digits_r <= load_digits;
      pend_dp_r     <= load_dp;
      pend_en_r     <= load_en;
      pend_full_r   <= 1'b1;
    end else begin
      pend_full_r   <= pend_full_r;
    end
  end

  // Active image: replaced only on the frame wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_digits_r <= '0;
      act_dp_r     <= '0;
      act_en_r     <= '0;
    end else if (swap_s) begin
      act_digits_r <= pend_digits_r;
      act_dp_r     <= pend_dp_r;
      act_en_r     <= pend_en_r;
    end else begin
      act_digits_r <= act_digits_r;
      act_dp_r     <= act_dp_r;
      act_en_r     <= act_en_r;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_next_s;
  logic [NUM_DIGITS-1:0] blank_r;

  // Leading-zero mask of the pending image, scanned from the top position
  // down; disabled positions neither blank nor end the leading run.
  always_comb begin
    logic stop_v;
    blank_next_s = '0;
    stop_v       = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (stop_v) begin
        blank_next_s[i] = 1'b0;
      end else if (!pend_en_r[i]) begin
        blank_next_s[i] = 1'b0;
      end else if ((pend_digits_r[i*4 +: 4] == 4'd0) && !pend_dp_r[i]) begin
        blank_next_s[i] = 1'b1;
      end else begin
        blank_next_s[i] = 1'b0;
        stop_v          = 1'b1;
      end
    end
  end

  // Blank mask captured alongside the active image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_r <= '0;
    end else if (swap_s) begin
      blank_r <= blank_next_s;
    end else begin
      blank_r <= blank_r;
    end
  end

  assign blank_mask_s = blank_r;
`else
  assign blank_mask_s = '0;
`endif

  assign code_s = act_digits_r[{idx_r, 2'b00} +: 4];
  assign dp_s   = act_dp_r[idx_r];
  assign lit_s  = act_en_r[idx_r] && !blank_mask_s[idx_r];

  seg_decode u_decode (
    .code (code_s),
    .dp   (dp_s),
    .seg  (dec_seg_s)
  );

  // Next output pattern; the tick edge loads the dead cycle of the new slot.
  always_comb begin
    an_next_s  = '1;
    seg_next_s = SEG_BLANK;
    if (tick_s) begin
      an_next_s  = '1;
      seg_next_s = SEG_BLANK;
    end else if (lit_s) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_next_s[i] = ~(idx_r == IDX_W'(i));
      end
      seg_next_s = dec_seg_s;
    end else begin
      an_next_s  = '1;
      seg_next_s = SEG_BLANK;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r        <= SEG_BLANK;
      an_r         <= '1;
      frame_done_r <= 1'b0;
    end else begin
      seg_r        <= seg_next_s;
      an_r         <= an_next_s;
      frame_done_r <= wrap_s;
    end
  end

  assign seg        = seg_r;
  assign an         = an_r;
  assign frame_done = frame_done_r;

endmodule
